data_mem_master: RTL and testbench
==================================

Name: data_mem_master

Overview:
Initiator side of the data-memory interface. It accepts byte, half, word and doubleword load/store requests from the pipeline MEM stage and drives the memory's read/write strobes, address and write data. The memory it talks to always transfers 8 bytes, big-endian: the byte at `address` is bits [63:56], with a combinational read and a write on the clock edge. So this block extracts and extends sub-doubleword loads, and performs read-modify-write for sub-doubleword stores. It sits between the MEM-stage control and the 1 KiB byte-addressed data memory.

Parameters:
- ADDR_BITS, 10, byte-address width of the memory (depth 2^ADDR_BITS bytes).
- CHECK_ALIGN, 0, when 1, an address not a multiple of the access size faults.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- req_unsigned  in  1  zero-extend loads (LBU/LHU/LWU)
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  load result, extended; 0 for stores and faults
- resp_fault  out  1  access fault, qualified by resp_valid
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- address  out  64  memory byte address
- write_data  out  64  8 bytes to memory, big-endian
- read_data  in  64  8 bytes from memory, combinational

Behaviour:
- N = 1 << req_size bytes.
- Reset (reset=0, async) values:
  - state = IDLE.
  - resp_valid = 0, resp_fault = 0, resp_rdata = 0.
  - MemRead = 0, MemWrite = 0, address = 0, write_data = 0.
  - req_ready = 1 once reset is released.
- Handshake:
  - req_ready = (state == IDLE).
  - A request is accepted on a rising edge with req_valid & req_ready.
  - All request fields are latched at acceptance; later changes to the inputs are ignored.
- Fault, checked at acceptance: any of
  - req_addr[63:ADDR_BITS] != 0;
  - req_addr[ADDR_BITS-1:0] > 2^ADDR_BITS - 8 (the memory always touches 8 bytes, so no wrap is permitted);
  - CHECK_ALIGN = 1 and the address is misaligned for the access size.
- States:
  - IDLE: on acceptance, go to
    - RESP with fault if the fault check fails;
    - LOAD for a load;
    - WRITE for a D store;
    - RMW_RD for a B/H/W store.
  - LOAD: MemRead = 1, address = latched address.
    - Register resp_rdata = read_data[63 -: 8N], sign- or zero-extended to 64 bits.
    - Go to RESP.
  - RMW_RD: MemRead = 1.
    - Register merge = {wdata[8N-1:0], read_data[63-8N:0]}.
    - Go to WRITE.
  - WRITE: MemWrite = 1 for exactly one cycle.
    - write_data = merge (sub-D stores) or the latched wdata (D stores).
    - Go to RESP.
  - RESP: resp_valid = 1 for one cycle, then IDLE.
    - resp_fault = 1 only for faulted requests; resp_rdata = 0 for stores and faults.
- Latency from the acceptance edge to the resp_valid cycle:
  - fault: 1 cycle;
  - load: 2 cycles;
  - D store: 2 cycles;
  - B/H/W store: 3 cycles.
- Strobes and memory-side outputs:
  - MemRead/MemWrite are decoded from registered state only; they are never asserted together, and never asserted for a faulted request.
  - address/write_data hold their last value outside access states.
- A new request may be accepted in the cycle after RESP (back-to-back throughput of one request per latency + 1 cycles).
- Reset mid-operation:
  - the state returns to IDLE immediately and any pending MemWrite is suppressed, so memory is not modified;
  - no resp_valid is produced for the aborted request.
- Stores never modify bytes outside [A, A+N-1]: the RMW write-back rewrites A+N..A+7 with the values just read.

Decomposition:
- Package dmm_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - the state enum (IDLE, LOAD, RMW_RD, WRITE, RESP);
  - the default ADDR_BITS.
- One combinational sub-module, dmm_lane, covers load extract/extend and store merge from (size, unsigned, read_data, wdata). The FSM lives in the top level.

Test Plan (memory initially all zero):
- Store D 0x1122334455667788 at 0x10, then load D at 0x10 -> resp_rdata 0x1122334455667788; the store's resp_valid comes 2 cycles after acceptance.
- Store B 0xAB at 0x12, then load D at 0x10 -> 0x1122AB4455667788. During the store, one MemRead cycle precedes one MemWrite cycle with write_data 0xAB44556677880000.
- Load B at 0x12 signed -> 0xFFFFFFFFFFFFFFAB; with req_unsigned=1 -> 0x00000000000000AB. Load H signed at 0x14 (0x5566) -> 0x0000000000005566.
- Store H 0xBEEF at 0x16, then load D at 0x10 -> 0x1122AB445566BEEF; load D at 0x18 -> 0.
- Load at 0x3FC and store at 0x400 -> resp_fault=1 and resp_rdata=0 one cycle after acceptance; MemRead and MemWrite stay 0.
- Pull reset low during the RMW_RD cycle of a store B at 0x20 -> no MemWrite and no resp_valid; req_ready=1 after release; load D at 0x20 returns 0.

Source files
------------

// File: rtl/dmm_pkg.sv
// Shared definitions for the data-memory master.
//   - access size encodings (SZ_B/H/W/D, matching req_size)
//   - FSM state enum
//   - default byte-address width of the attached memory
package dmm_pkg;

  localparam int DMM_ADDR_BITS = 10;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/dmm_lane.sv
// Combinational byte-lane datapath for the data-memory master.
// The memory word is big-endian: the addressed byte sits in rdata[63:56].
//   size_i  : access size (SZ_B..SZ_D)
//   uns_i   : zero-extend loads instead of sign-extending them
//   rdata_i : 8 bytes read from memory at the access address
//   wdata_i : store data, right-aligned
//   ld_o    : extracted and extended load result
//   st_o    : 8-byte write-back word; the bytes past the access are the
//             ones just read, so a write-back leaves them unchanged
module dmm_lane
  import dmm_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] ld_o,
  output logic [63:0] st_o
);

  always_comb begin
    ld_o = rdata_i;
    st_o = wdata_i;
    unique case (size_i)
      SZ_B: begin
        ld_o = uns_i ? {56'd0, rdata_i[63:56]} : {{56{rdata_i[63]}}, rdata_i[63:56]};
        st_o = {wdata_i[7:0], rdata_i[55:0]};
      end
      SZ_H: begin
        ld_o = uns_i ? {48'd0, rdata_i[63:48]} : {{48{rdata_i[63]}}, rdata_i[63:48]};
        st_o = {wdata_i[15:0], rdata_i[47:0]};
      end
      SZ_W: begin
        ld_o = uns_i ? {32'd0, rdata_i[63:32]} : {{32{rdata_i[63]}}, rdata_i[63:32]};
        st_o = {wdata_i[31:0], rdata_i[31:0]};
      end
      default: begin
        ld_o = rdata_i;
        st_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_master.sv
// Initiator side of the data-memory interface.
// Accepts B/H/W/D loads and stores from the MEM stage and drives an 8-byte,
// big-endian memory (combinational read, write on the clock edge).
// Sub-doubleword loads are extracted/extended; sub-doubleword stores are
// done as read-modify-write.
//   clk, reset        : clock, async active-low reset
//   req_*             : request handshake and fields (latched on accept)
//   resp_*            : one-cycle completion pulse with load data / fault
//   MemRead/MemWrite  : memory strobes, decoded from state only
//   address           : memory byte address (held outside access states)
//   write_data        : 8-byte write word (held outside access states)
//   read_data         : 8-byte read word from memory
module data_mem_master
  import dmm_pkg::*;
#(
  parameter int ADDR_BITS   = DMM_ADDR_BITS,
  parameter bit CHECK_ALIGN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [63:0] address,
  output logic [63:0] write_data,
  input  logic [63:0] read_data
);

  // Highest legal start address: every access touches 8 bytes, no wrap.
  localparam logic [ADDR_BITS-1:0] LAST_A = ADDR_BITS'((1 << ADDR_BITS) - 8);

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] wdata_q;
  logic [63:0] address_q, write_data_q, resp_rdata_q;
  logic        resp_fault_q;

  logic        accept, fault;
  logic [63:0] size_mask;
  logic [63:0] ld_ext, st_merge;

  assign accept    = req_valid & req_ready;
  assign size_mask = (64'd1 << req_size) - 64'd1;
  assign fault     = ((req_addr >> ADDR_BITS) != 64'd0)
                   | (req_addr[ADDR_BITS-1:0] > LAST_A)
                   | (CHECK_ALIGN && ((req_addr & size_mask) != 64'd0));

  dmm_lane u_lane (
    .size_i  (size_q),
    .uns_i   (uns_q),
    .rdata_i (read_data),
    .wdata_i (wdata_q),
    .ld_o    (ld_ext),
    .st_o    (st_merge)
  );

  // State register. Reset drops straight to IDLE, which also kills any
  // MemWrite that would have happened for an in-flight store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (fault)               state_d = RESP;
        else if (!req_write)     state_d = LOAD;
        else if (req_size == SZ_D) state_d = WRITE;
        else                     state_d = RMW_RD;
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    MemRead    = (state_q == LOAD) || (state_q == RMW_RD);
    MemWrite   = (state_q == WRITE);
    resp_valid = (state_q == RESP);
  end

  // Datapath. address/write_data are loaded ahead of the access state so
  // they are stable for the whole strobe cycle; write_data doubles as the
  // RMW merge register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      if (accept) begin
        size_q       <= req_size;
        uns_q        <= req_unsigned;
        wdata_q      <= req_wdata;
        resp_fault_q <= fault;
        resp_rdata_q <= '0;
        if (!fault) begin
          address_q <= req_addr;
          if (req_write && req_size == SZ_D) write_data_q <= req_wdata;
        end
      end
      if (state_q == LOAD)   resp_rdata_q <= ld_ext;
      if (state_q == RMW_RD) write_data_q <= st_merge;
    end
  end

  assign address    = address_q;
  assign write_data = write_data_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_data_mem_master.sv
module tb_data_mem_master;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        flt;
    int          lat;
    int          nrd;
    int          nwr;
    logic        chk_wd;
    logic [63:0] wd;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        flt;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, MemRead, MemWrite;
  logic [63:0] resp_rdata, address, write_data, read_data;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  logic [7:0] mem [0:1023];
  logic       mem_clr = 1'b1;

  always #5 clk = ~clk;

  data_mem_master #(.ADDR_BITS(10), .CHECK_ALIGN(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  // Big-endian 8-byte memory: combinational read, write on the edge.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < 8; i++)
      read_data[63-8*i -: 8] = mem[address[9:0] + 10'(i)];
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (MemWrite) begin
      for (int i = 0; i < 8; i++) mem[address[9:0] + 10'(i)] <= write_data[63-8*i -: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input logic flt, input int lat,
                              input int nrd, input int nwr, input logic chk_wd,
                              input logic [63:0] wd);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.flt = flt; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    v.chk_wd = chk_wd; v.wd = wd;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int   w, nrd, nwr, lat;
    logic got;
    exp_t e;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL ready_timeout[%0d]: req_ready stayed 0", idx);
      return;
    end
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    e.rdata = v.rdata; e.flt = v.flt; e.lat = v.lat; e.nrd = v.nrd; e.nwr = v.nwr;
    sb.push_back(e);
    // Scramble inputs: the DUT must work from its latched copy.
    req_valid = 1'b0; req_write = ~v.wr; req_size = ~v.sz; req_unsigned = ~v.uns;
    req_addr = 64'h5A5A_5A5A_5A5A_5A5A; req_wdata = 64'hC3C3_C3C3_C3C3_C3C3;
    nrd = 0; nwr = 0; lat = 0; got = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (MemRead || MemWrite) chk($sformatf("address[%0d]", idx), address, v.addr);
      if (MemRead && MemWrite) chk($sformatf("strobe_overlap[%0d]", idx), 64'd1, 64'd0);
      if (MemWrite && v.chk_wd) chk($sformatf("write_data[%0d]", idx), write_data, v.wd);
      nrd += int'(MemRead);
      nwr += int'(MemWrite);
      if (resp_valid) begin got = 1'b1; lat = c; end
    end
    e = sb.pop_front();
    if (!got) begin
      errors++; checks++;
      $display("FAIL resp_timeout[%0d]: no resp_valid within 8 cycles", idx);
    end else begin
      chk($sformatf("rdata[%0d]", idx), resp_rdata, e.rdata);
      chk($sformatf("fault[%0d]", idx), 64'(resp_fault), 64'(e.flt));
      chk($sformatf("latency[%0d]", idx), 64'(lat), 64'(e.lat));
      chk($sformatf("nread[%0d]", idx), 64'(nrd), 64'(e.nrd));
      chk($sformatf("nwrite[%0d]", idx), 64'(nwr), 64'(e.nwr));
    end
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1, 2'd3, 0, 64'h010, 64'h1122334455667788, 64'h0, 0, 2, 0, 1, 1, 64'h1122334455667788);
    tbl[1]  = mk(0, 2'd3, 0, 64'h010, 64'h0, 64'h1122334455667788, 0, 2, 1, 0, 0, 64'h0);
    tbl[2]  = mk(1, 2'd0, 0, 64'h012, 64'hFFFFFFFFFFFFFFAB, 64'h0, 0, 3, 1, 1, 1, 64'hAB44556677880000);
    tbl[3]  = mk(0, 2'd3, 0, 64'h010, 64'h0, 64'h1122AB4455667788, 0, 2, 1, 0, 0, 64'h0);
    tbl[4]  = mk(0, 2'd0, 0, 64'h012, 64'h0, 64'hFFFFFFFFFFFFFFAB, 0, 2, 1, 0, 0, 64'h0);
    tbl[5]  = mk(0, 2'd0, 1, 64'h012, 64'h0, 64'h00000000000000AB, 0, 2, 1, 0, 0, 64'h0);
    tbl[6]  = mk(0, 2'd1, 0, 64'h014, 64'h0, 64'h0000000000005566, 0, 2, 1, 0, 0, 64'h0);
    tbl[7]  = mk(1, 2'd1, 0, 64'h016, 64'h000000000000BEEF, 64'h0, 0, 3, 1, 1, 1, 64'hBEEF000000000000);
    tbl[8]  = mk(0, 2'd3, 0, 64'h010, 64'h0, 64'h1122AB445566BEEF, 0, 2, 1, 0, 0, 64'h0);
    tbl[9]  = mk(0, 2'd3, 0, 64'h018, 64'h0, 64'h0, 0, 2, 1, 0, 0, 64'h0);
    tbl[10] = mk(0, 2'd1, 0, 64'h016, 64'h0, 64'hFFFFFFFFFFFFBEEF, 0, 2, 1, 0, 0, 64'h0);
    tbl[11] = mk(0, 2'd2, 1, 64'h014, 64'h0, 64'h000000005566BEEF, 0, 2, 1, 0, 0, 64'h0);
    tbl[12] = mk(0, 2'd2, 0, 64'h012, 64'h0, 64'hFFFFFFFFAB445566, 0, 2, 1, 0, 0, 64'h0);
    tbl[13] = mk(1, 2'd2, 0, 64'h3F8, 64'h12345678DEADBEEF, 64'h0, 0, 3, 1, 1, 1, 64'hDEADBEEF00000000);
    tbl[14] = mk(0, 2'd3, 0, 64'h3F8, 64'h0, 64'hDEADBEEF00000000, 0, 2, 1, 0, 0, 64'h0);
    tbl[15] = mk(0, 2'd3, 0, 64'h3FC, 64'h0, 64'h0, 1, 1, 0, 0, 0, 64'h0);
    tbl[16] = mk(1, 2'd3, 0, 64'h400, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 1, 0, 0, 0, 64'h0);
    tbl[17] = mk(1, 2'd0, 0, 64'h3F9, 64'h11, 64'h0, 1, 1, 0, 0, 0, 64'h0);
    tbl[18] = mk(0, 2'd2, 1, 64'h3F8, 64'h0, 64'h00000000DEADBEEF, 0, 2, 1, 0, 0, 64'h0);
    tbl[19] = mk(0, 2'd0, 0, 64'h3FF, 64'h0, 64'h0, 1, 1, 0, 0, 0, 64'h0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_fault", 64'(resp_fault), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_MemRead",    64'(MemRead), 64'd0);
    chk("rst_MemWrite",   64'(MemWrite), 64'd0);
    chk("rst_address",    address, 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    mem_clr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 20; i++) run_vec(i, tbl[i]);

    // Reset during the RMW read of a byte store: nothing must reach memory.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h020; req_wdata = 64'hCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_rmw_rd", 64'(MemRead), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_MemWrite", 64'(MemWrite), 64'd0);
    chk("midrst_MemRead",  64'(MemRead), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midrst_hold_wr",   64'(MemWrite), 64'd0);
      chk("midrst_hold_resp", 64'(resp_valid), 64'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("postrst_ready", 64'(req_ready), 64'd1);
      chk("postrst_resp",  64'(resp_valid), 64'd0);
      chk("postrst_wr",    64'(MemWrite), 64'd0);
    end
    run_vec(20, mk(0, 2'd3, 0, 64'h020, 64'h0, 64'h0, 0, 2, 1, 0, 0, 64'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
